// File: rtl/threeway_pi_pipe.sv
// ---------------------------------------------------------------------------
// threeway_pi_pipe
//
// Elastic, pipelined pi1/pi2 permutation for the 3-Way round datapath.
// A 3-word block is permuted combinationally on the way into stage 0.
// It then travels through STAGES register stages under a valid/ready
// handshake with full backpressure.
//
// Word a1 always passes through unchanged.
//   pi2 (imode=0): a0' = a0 rotl ROT_S, a2' = a2 rotr ROT_L
//   pi1 (imode=1): a0' = a0 rotr ROT_L, a2' = a2 rotl ROT_S
//
// Optional feature, enabled with macro THREEWAY_PI_INV_EN:
//   This adds the input iinv. When iinv=1 the inverse of the selected
//   permutation is applied, which the decryption round needs.
//
// Parameters:
//   WORD_W  width of each word (block is 3*WORD_W)
//   ROT_L   long rotation amount, 0 < ROT_L < WORD_W
//   ROT_S   short rotation amount, 0 < ROT_S < WORD_W
//   STAGES  number of register stages (= latency), >= 1
//
// Ports:
//   clk     clock, rising edge
//   rst_n   synchronous active-low reset
//   ivalid  input block valid
//   iready  input accepted when ivalid && iready
//   imode   0 = pi2, 1 = pi1, sampled with iword
//   iinv    (THREEWAY_PI_INV_EN only) apply inverse permutation
//   iword   packed block: a0=[W-1:0], a1=[2W-1:W], a2=[3W-1:2W]
//   ovalid  output block valid
//   oready  downstream accepts when ovalid && oready
//   oword   permuted block, same packing
//   count   number of blocks currently held in the pipe
// ---------------------------------------------------------------------------
module threeway_pi_pipe #(
    parameter int WORD_W = 32,
    parameter int ROT_L  = 10,
    parameter int ROT_S  = 1,
    parameter int STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ivalid,
    output logic                         iready,
    input  logic                         imode,
`ifdef THREEWAY_PI_INV_EN
    input  logic                         iinv,
`endif
    input  logic [3*WORD_W-1:0]          iword,
    output logic                         ovalid,
    input  logic                         oready,
    output logic [3*WORD_W-1:0]          oword,
    output logic [$clog2(STAGES+1)-1:0]  count
);

    localparam int BLK_W = 3 * WORD_W;
    localparam int CNT_W = $clog2(STAGES + 1);

    // Elaboration-time parameter checks.
    if (ROT_L < 1 || ROT_L >= WORD_W) begin : g_bad_rot_l
        $error("threeway_pi_pipe: ROT_L=%0d must be in 1..WORD_W-1", ROT_L);
    end
    if (ROT_S < 1 || ROT_S >= WORD_W) begin : g_bad_rot_s
        $error("threeway_pi_pipe: ROT_S=%0d must be in 1..WORD_W-1", ROT_S);
    end
    if (STAGES < 1) begin : g_bad_stages
        $error("threeway_pi_pipe: STAGES=%0d must be >= 1", STAGES);
    end

    // Pure bit rotations. The rotation amounts are parameters, so these
    // reduce to wiring.
    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                               input int unsigned       n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned       n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    logic [WORD_W-1:0] a0;
    logic [WORD_W-1:0] a1;
    logic [WORD_W-1:0] a2;
    logic [WORD_W-1:0] p0;
    logic [WORD_W-1:0] p2;
    logic [BLK_W-1:0]  perm;

    assign a0 = iword[WORD_W-1:0];
    assign a1 = iword[2*WORD_W-1:WORD_W];
    assign a2 = iword[3*WORD_W-1:2*WORD_W];

    // Permutation ahead of stage 0. When enabled, the inverse swaps the
    // rotation directions, so each forward mode is undone exactly.
    always_comb begin
        if (imode) begin
            p0 = rotr(a0, ROT_L);
            p2 = rotl(a2, ROT_S);
        end else begin
            p0 = rotl(a0, ROT_S);
            p2 = rotr(a2, ROT_L);
        end
`ifdef THREEWAY_PI_INV_EN
        if (iinv) begin
            if (imode) begin
                p0 = rotl(a0, ROT_L);
                p2 = rotr(a2, ROT_S);
            end else begin
                p0 = rotr(a0, ROT_S);
                p2 = rotl(a2, ROT_L);
            end
        end
`endif
        perm = {p2, a1, p0};
    end

    // Pipeline state.
    logic [STAGES-1:0] valid_q;
    logic [BLK_W-1:0]  data_q [STAGES];
    logic [CNT_W-1:0]  count_q;

    // Stall chain.
    //   advance[k]: the content of stage k moves on at the next edge.
    //   load[k]:    stage k takes in its upstream content.
    // The chain runs from oready backwards. An empty stage downstream lets
    // everything behind it move, which collapses bubbles.
    logic [STAGES-1:0] advance;
    logic [STAGES-1:0] load;

    always_comb begin
        logic chain;
        chain = oready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            advance[k] = chain;
            load[k]    = chain || !valid_q[k];
            chain      = chain || !valid_q[k];
        end
    end

    // Stage inputs: stage 0 is fed by the permutation, later stages by
    // their predecessor.
    logic [STAGES-1:0] in_valid;
    logic [BLK_W-1:0]  in_data [STAGES];

    always_comb begin
        in_valid[0] = ivalid;
        in_data[0]  = perm;
        for (int k = 1; k < STAGES; k++) begin
            in_valid[k] = valid_q[k-1];
            in_data[k]  = data_q[k-1];
        end
    end

    logic accept;
    logic emit;

    assign iready = load[0];
    assign accept = ivalid && iready;
    assign emit   = valid_q[STAGES-1] && oready;

    // Stage registers.
    // - A loading stage takes its upstream valid bit and data.
    // - A stalled stage holds both unchanged.
    // - Reset clears everything, including the data, so that nothing is X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= in_valid[k];
                    data_q[k]  <= in_data[k];
                end
            end
        end
    end

    // Occupancy counter.
    // - Accept and emit in the same cycle cancel each other.
    // - Accept alone increments; emit alone decrements.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            case ({accept, emit})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign ovalid = valid_q[STAGES-1];
    assign oword  = data_q[STAGES-1];
    assign count  = count_q;

endmodule
